// File: rtl/xo_game_engine.sv
// N x N, K-in-a-row noughts-and-crosses engine: cursor, board, turn, a
// one-candidate-per-cycle win scan, win/tie detection and saturating scores.
module xo_game_engine #(
  parameter int BOARD_N   = 3,
  parameter int WIN_LEN   = 3,
  parameter int SCORE_W   = 4,
  parameter int WRAP      = 0,
  parameter int ALT_START = 0,
  localparam int CELLS    = BOARD_N * BOARD_N,
  localparam int IDX_W    = $clog2(CELLS)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_sel,
  input  logic               new_game,
  input  logic               clear_scores,
  output logic [IDX_W-1:0]   cursor,
  output logic [CELLS-1:0]   cell_used,
  output logic [CELLS-1:0]   cell_sign,
  output logic               turn,
  output logic [1:0]         state,
  output logic               busy,
  output logic               winner,
  output logic [IDX_W-1:0]   win_start,
  output logic [1:0]         win_dir,
  output logic [IDX_W:0]     move_count,
  output logic [SCORE_W-1:0] x_score,
  output logic [SCORE_W-1:0] o_score
);

  typedef enum logic [1:0] {ST_PLAY = 2'd0, ST_CHECK = 2'd1, ST_WIN = 2'd2, ST_TIE = 2'd3} state_t;

  localparam logic [IDX_W-1:0] CENTER   = IDX_W'(CELLS / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [IDX_W-1:0] STEP_N   = IDX_W'(BOARD_N);
  localparam logic [IDX_W-1:0] NM1      = IDX_W'(BOARD_N - 1);
  localparam logic [IDX_W-1:0] SPAN     = IDX_W'((BOARD_N - 1) * BOARD_N);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] LIM      = IDX_W'(BOARD_N - WIN_LEN);
  localparam logic [IDX_W-1:0] KM1      = IDX_W'(WIN_LEN - 1);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W + 1)'(CELLS);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cursor_q, cursor_d, scan_idx_q, scan_idx_d, win_start_q, win_start_d;
  logic [1:0]         scan_dir_q, scan_dir_d, win_dir_q, win_dir_d;
  logic [CELLS-1:0]   used_q, used_d, sign_q, sign_d;
  logic               turn_q, turn_d, start_q, start_d, winner_q, winner_d, busy_q, busy_d;
  logic [IDX_W:0]     moves_q, moves_d;
  logic [SCORE_W-1:0] x_score_q, x_score_d, o_score_q, o_score_d;

  logic               place_en, restart_en, hit, in_bounds, scan_last;
  logic [IDX_W-1:0]   scan_row, scan_col, step, probe;
  logic [IDX_W-1:0]   cur_row, cur_col, cur_up, cur_down, cur_left, cur_right;

  // A pending new_game/clear_scores swallows every other button in the same cycle.
  assign place_en   = (state_q == ST_PLAY) && btn_sel && !new_game && !clear_scores && !used_q[cursor_q];
  assign restart_en = new_game ||
                      (((state_q == ST_WIN) || (state_q == ST_TIE)) && btn_sel && !clear_scores);
  assign scan_last  = (scan_idx_q == LAST_IDX) && (scan_dir_q == 2'd3);

  always_comb begin
    cur_row   = cursor_q / STEP_N;
    cur_col   = cursor_q % STEP_N;
    cur_up    = cursor_q;
    cur_down  = cursor_q;
    cur_left  = cursor_q;
    cur_right = cursor_q;
    if (cur_row != '0)       cur_up    = cursor_q - STEP_N;
    else if (WRAP != 0)      cur_up    = cursor_q + SPAN;
    if (cur_row != NM1)      cur_down  = cursor_q + STEP_N;
    else if (WRAP != 0)      cur_down  = cursor_q - SPAN;
    if (cur_col != '0)       cur_left  = cursor_q - ONE;
    else if (WRAP != 0)      cur_left  = cursor_q + NM1;
    if (cur_col != NM1)      cur_right = cursor_q + ONE;
    else if (WRAP != 0)      cur_right = cursor_q - NM1;
  end

  // Probe indices wrap modulo 2^IDX_W only for out-of-bounds candidates, which are masked.
  always_comb begin
    scan_row  = scan_idx_q / STEP_N;
    scan_col  = scan_idx_q % STEP_N;
    in_bounds = 1'b0;
    step      = ONE;
    probe     = '0;
    case (scan_dir_q)
      2'd0:    begin in_bounds = (scan_col <= LIM);                      step = ONE;          end
      2'd1:    begin in_bounds = (scan_row <= LIM);                      step = STEP_N;       end
      2'd2:    begin in_bounds = (scan_col <= LIM) && (scan_row <= LIM); step = STEP_N + ONE; end
      default: begin in_bounds = (scan_col >= KM1) && (scan_row <= LIM); step = STEP_N - ONE; end
    endcase
    hit = in_bounds;
    for (int k = 0; k < WIN_LEN; k++) begin
      probe = scan_idx_q + IDX_W'(k) * step;
      if (!used_q[probe] || (sign_q[probe] != sign_q[scan_idx_q])) hit = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_PLAY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart_en) begin
      state_d = ST_PLAY;
    end else begin
      case (state_q)
        ST_PLAY:  if (place_en) state_d = ST_CHECK;
        ST_CHECK: begin
          if (hit)            state_d = ST_WIN;
          else if (scan_last) state_d = (moves_q == FULL_CNT) ? ST_TIE : ST_PLAY;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cursor_d    = cursor_q;
    used_d      = used_q;
    sign_d      = sign_q;
    turn_d      = turn_q;
    start_d     = start_q;
    moves_d     = moves_q;
    scan_idx_d  = scan_idx_q;
    scan_dir_d  = scan_dir_q;
    winner_d    = winner_q;
    win_start_d = win_start_q;
    win_dir_d   = win_dir_q;
    x_score_d   = x_score_q;
    o_score_d   = o_score_q;
    busy_d      = (state_d == ST_CHECK);
    if (restart_en) begin
      used_d   = '0;
      sign_d   = '0;
      moves_d  = '0;
      cursor_d = CENTER;
      if (ALT_START != 0) begin
        start_d = ~start_q;
        turn_d  = ~start_q;
      end else begin
        turn_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (place_en) begin
            used_d[cursor_q] = 1'b1;
            sign_d[cursor_q] = turn_q;
            moves_d          = moves_q + 1'b1;
            scan_idx_d       = '0;
            scan_dir_d       = '0;
          end else if (!btn_sel && !clear_scores) begin
            if (btn_up)         cursor_d = cur_up;
            else if (btn_down)  cursor_d = cur_down;
            else if (btn_left)  cursor_d = cur_left;
            else if (btn_right) cursor_d = cur_right;
          end
        end
        ST_CHECK: begin
          if (hit) begin
            winner_d    = sign_q[scan_idx_q];
            win_start_d = scan_idx_q;
            win_dir_d   = scan_dir_q;
            if (sign_q[scan_idx_q]) o_score_d = sat_inc(o_score_q);
            else                    x_score_d = sat_inc(x_score_q);
          end else if (scan_last) begin
            if (moves_q != FULL_CNT) turn_d = ~turn_q;
          end else begin
            scan_dir_d = scan_dir_q + 2'd1;
            if (scan_dir_q == 2'd3) scan_idx_d = scan_idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (clear_scores) begin
      x_score_d = '0;
      o_score_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor_q    <= CENTER;
      used_q      <= '0;
      sign_q      <= '0;
      turn_q      <= 1'b0;
      start_q     <= 1'b0;
      moves_q     <= '0;
      scan_idx_q  <= '0;
      scan_dir_q  <= '0;
      winner_q    <= 1'b0;
      win_start_q <= '0;
      win_dir_q   <= '0;
      x_score_q   <= '0;
      o_score_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      cursor_q    <= cursor_d;
      used_q      <= used_d;
      sign_q      <= sign_d;
      turn_q      <= turn_d;
      start_q     <= start_d;
      moves_q     <= moves_d;
      scan_idx_q  <= scan_idx_d;
      scan_dir_q  <= scan_dir_d;
      winner_q    <= winner_d;
      win_start_q <= win_start_d;
      win_dir_q   <= win_dir_d;
      x_score_q   <= x_score_d;
      o_score_q   <= o_score_d;
      busy_q      <= busy_d;
    end
  end

  assign cursor     = cursor_q;
  assign cell_used  = used_q;
  assign cell_sign  = sign_q;
  assign turn       = turn_q;
  assign state      = state_q;
  assign busy       = busy_q;
  assign winner     = winner_q;
  assign win_start  = win_start_q;
  assign win_dir    = win_dir_q;
  assign move_count = moves_q;
  assign x_score    = x_score_q;
  assign o_score    = o_score_q;

endmodule

// File: tb/tb_xo_game_engine.sv
// Bench for xo_game_engine: a 3x3 clamp instance and a 4x4 wrap/alternating
// instance share one button bus and are tracked by a row/column game model.
module tb_xo_game_engine;

  logic clock, reset_n;
  logic btn_up, btn_down, btn_left, btn_right, btn_sel, new_game, clear_scores;

  logic [3:0] a_cursor, a_ws;  logic [8:0] a_used, a_sign;  logic [4:0] a_mc;
  logic a_turn, a_busy, a_winner;  logic [1:0] a_state, a_wd, a_xs, a_os;
  logic [3:0] b_cursor, b_ws;  logic [15:0] b_used, b_sign; logic [4:0] b_mc;
  logic b_turn, b_busy, b_winner;  logic [1:0] b_state, b_wd;  logic [3:0] b_xs, b_os;

  xo_game_engine #(.BOARD_N(3), .WIN_LEN(3), .SCORE_W(2), .WRAP(0), .ALT_START(0)) u_a (
    .clock(clock), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel), .new_game(new_game),
    .clear_scores(clear_scores), .cursor(a_cursor), .cell_used(a_used), .cell_sign(a_sign),
    .turn(a_turn), .state(a_state), .busy(a_busy), .winner(a_winner), .win_start(a_ws),
    .win_dir(a_wd), .move_count(a_mc), .x_score(a_xs), .o_score(a_os));

  xo_game_engine #(.BOARD_N(4), .WIN_LEN(3), .SCORE_W(4), .WRAP(1), .ALT_START(1)) u_b (
    .clock(clock), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel), .new_game(new_game),
    .clear_scores(clear_scores), .cursor(b_cursor), .cell_used(b_used), .cell_sign(b_sign),
    .turn(b_turn), .state(b_state), .busy(b_busy), .winner(b_winner), .win_start(b_ws),
    .win_dir(b_wd), .move_count(b_mc), .x_score(b_xs), .o_score(b_os));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef logic [174:0] snap_t;
  snap_t obs_a, obs_b;
  assign obs_a = {8'(a_cursor), 64'(a_used), 64'(a_sign), a_turn, a_state, a_busy, a_winner,
                  8'(a_ws), a_wd, 8'(a_mc), 8'(a_xs), 8'(a_os)};
  assign obs_b = {8'(b_cursor), 64'(b_used), 64'(b_sign), b_turn, b_state, b_busy, b_winner,
                  8'(b_ws), b_wd, 8'(b_mc), 8'(b_xs), 8'(b_os)};

  localparam logic [6:0] B_NG = 7'b1000000, B_CS = 7'b0100000, B_SEL = 7'b0010000;
  localparam logic [6:0] B_UP = 7'b0001000, B_DN = 7'b0000100, B_LF = 7'b0000010, B_RT = 7'b0000001;

  int checks = 0;
  int errors = 0;

  // Model: index 0 is the 3x3 instance, index 1 the 4x4 instance.
  int PN[2]  = '{3, 4};
  int PK[2]  = '{3, 3};
  int PSW[2] = '{2, 4};
  int PWR[2] = '{0, 1};
  int PAL[2] = '{0, 1};
  int mst[2], mcur[2], mturn[2], mstart[2], mwin[2], mws[2], mwd[2], mmc[2], mxs[2], mos[2];
  int mleft[2], mhit[2], mhidx[2], mhdir[2];
  bit mused[2][64];
  bit msgn[2][64];

  function automatic snap_t obs_of(input int m);
    return (m == 0) ? obs_a : obs_b;
  endfunction

  function automatic snap_t model_snap(input int m);
    logic [63:0] u, s;
    u = '0; s = '0;
    for (int i = 0; i < PN[m] * PN[m]; i++) begin u[i] = mused[m][i]; s[i] = msgn[m][i]; end
    return {8'(mcur[m]), u, s, 1'(mturn[m]), 2'(mst[m]), (mst[m] == 1), 1'(mwin[m]),
            8'(mws[m]), 2'(mwd[m]), 8'(mmc[m]), 8'(mxs[m]), 8'(mos[m])};
  endfunction

  function automatic void mclear(input int m);
    for (int i = 0; i < 64; i++) begin mused[m][i] = 0; msgn[m][i] = 0; end
    mst[m] = 0; mmc[m] = 0; mcur[m] = PN[m] * PN[m] / 2;
  endfunction

  function automatic void mreset(input int m);
    mclear(m);
    mturn[m] = 0; mstart[m] = 0; mwin[m] = 0; mws[m] = 0; mwd[m] = 0; mxs[m] = 0; mos[m] = 0;
  endfunction

  function automatic void mnew(input int m);
    mclear(m);
    if (PAL[m] != 0) begin mstart[m] = 1 - mstart[m]; mturn[m] = mstart[m]; end
    else mturn[m] = 0;
  endfunction

  // K cells from (row,col) of idx along direction d, all on the board and sharing a mark.
  function automatic bit mline(input int m, input int idx, input int d);
    int n, r, c, dr, dc;
    n = PN[m];
    dr = (d == 0) ? 0 : 1;
    dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
    for (int k = 0; k < PK[m]; k++) begin
      r = idx / n + k * dr;
      c = idx % n + k * dc;
      if (r < 0 || r >= n || c < 0 || c >= n) return 0;
      if (!mused[m][r * n + c] || msgn[m][r * n + c] != msgn[m][idx]) return 0;
    end
    return 1;
  endfunction

  function automatic void mstep(input int m, input logic ng, cs, sel, up, dn, lf, rt);
    int n, r, c, cells, smax;
    n = PN[m]; cells = n * n; smax = (1 << PSW[m]) - 1;
    r = mcur[m] / n; c = mcur[m] % n;
    if (ng) mnew(m);
    else if (mst[m] == 0) begin
      if (!cs) begin
        if (sel) begin
          if (!mused[m][mcur[m]]) begin
            mused[m][mcur[m]] = 1; msgn[m][mcur[m]] = mturn[m][0]; mmc[m]++; mst[m] = 1;
            mhit[m] = 0; mleft[m] = 4 * cells;
            for (int i = 0; i < cells; i++)
              for (int d = 0; d < 4; d++)
                if (mhit[m] == 0 && mline(m, i, d)) begin
                  mhit[m] = 1; mhidx[m] = i; mhdir[m] = d; mleft[m] = 4 * i + d + 1;
                end
          end
        end else if (up) begin if (r > 0) r--; else if (PWR[m] != 0) r = n - 1; end
        else if (dn) begin if (r < n - 1) r++; else if (PWR[m] != 0) r = 0; end
        else if (lf) begin if (c > 0) c--; else if (PWR[m] != 0) c = n - 1; end
        else if (rt) begin if (c < n - 1) c++; else if (PWR[m] != 0) c = 0; end
        if (mst[m] == 0) mcur[m] = r * n + c;
      end
    end else if (mst[m] == 1) begin
      mleft[m]--;
      if (mleft[m] == 0) begin
        if (mhit[m] != 0) begin
          mst[m] = 2; mwin[m] = msgn[m][mhidx[m]]; mws[m] = mhidx[m]; mwd[m] = mhdir[m];
          if (mwin[m] != 0) begin if (mos[m] < smax) mos[m]++; end
          else begin if (mxs[m] < smax) mxs[m]++; end
        end else if (mmc[m] == cells) mst[m] = 3;
        else begin mst[m] = 0; mturn[m] = 1 - mturn[m]; end
      end
    end else if (sel && !cs) mnew(m);
    if (cs) begin mxs[m] = 0; mos[m] = 0; end
  endfunction

  task automatic tick();
    @(posedge clock);
    for (int m = 0; m < 2; m++)
      mstep(m, new_game, clear_scores, btn_sel, btn_up, btn_down, btn_left, btn_right);
    #1;
    {new_game, clear_scores, btn_sel, btn_up, btn_down, btn_left, btn_right} = '0;
  endtask

  task automatic press(input logic [6:0] b);
    {new_game, clear_scores, btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
    tick();
  endtask

  task automatic goto(input int m, input int target);
    int n;
    n = PN[m];
    for (int i = 0; i < 4 * n && mcur[m] != target; i++) begin
      if (mcur[m] / n > target / n)      press(B_UP);
      else if (mcur[m] / n < target / n) press(B_DN);
      else if (mcur[m] % n > target % n) press(B_LF);
      else                               press(B_RT);
    end
  endtask

  // Cycles the DUT reports busy, capped so a stuck scan cannot hang the run.
  task automatic run_check(input int m, output int n);
    n = 0;
    while (((m == 0) ? a_busy : b_busy) && n < 300) begin tick(); n++; end
  endtask

  task automatic place(input int m, input int target, output int dur);
    goto(m, target);
    press(B_SEL);
    run_check(m, dur);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    {new_game, clear_scores, btn_sel, btn_up, btn_down, btn_left, btn_right} = '0;
    repeat (2) @(posedge clock);
    #1;
    mreset(0); mreset(1);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== model_snap(m)) begin errors++;
        $display("FAIL reset_state dut%0d got %h expected %h", m, obs_of(m), model_snap(m)); end
    end
    checks++;
    if (a_cursor !== 4'd4 || b_cursor !== 4'd8) begin errors++;
      $display("FAIL reset_cursor got %0d/%0d expected 4/8", a_cursor, b_cursor); end
    #3 reset_n = 1'b1;
  endtask

  task automatic test_cursor();
    logic [6:0] seq[4] = '{B_UP, B_UP, B_LF, B_LF};
    int expc[4] = '{1, 1, 0, 0};
    int d;
    for (int i = 0; i < 4; i++) begin
      press(seq[i]);
      checks++;
      if (a_cursor !== 4'(expc[i])) begin errors++;
        $display("FAIL clamp_move%0d got %0d expected %0d", i, a_cursor, expc[i]); end
    end
    press(B_SEL);
    run_check(0, d);
    press(B_SEL);
    checks++;
    if (a_mc !== 5'd1 || a_state !== 2'd0) begin errors++;
      $display("FAIL sel_occupied move_count %0d state %0d expected 1 0", a_mc, a_state); end
    press(B_NG);
    press(B_LF);
    checks++;
    if (b_cursor !== 4'd11) begin errors++;
      $display("FAIL wrap_left got %0d expected 11", b_cursor); end
    repeat (3) press(B_UP);
    checks++;
    if (b_cursor !== 4'd15) begin errors++;
      $display("FAIL wrap_up got %0d expected 15", b_cursor); end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== model_snap(m)) begin errors++;
        $display("FAIL cursor_model dut%0d got %h expected %h", m, obs_of(m), model_snap(m)); end
    end
  endtask

  task automatic test_win_row();
    int cells[5] = '{0, 3, 1, 4, 2};
    int durs[5]  = '{36, 36, 36, 36, 1};
    int d;
    press(B_NG);
    for (int i = 0; i < 5; i++) begin
      place(0, cells[i], d);
      checks++;
      if (d != durs[i]) begin errors++;
        $display("FAIL row_check_cycles move%0d got %0d expected %0d", i, d, durs[i]); end
    end
    checks++;
    if (a_state !== 2'd2 || a_winner !== 1'b0 || a_ws !== 4'd0 || a_wd !== 2'd0 ||
        a_xs !== 2'd1 || a_os !== 2'd0) begin errors++;
      $display("FAIL row_win state %0d winner %0d start %0d dir %0d x %0d o %0d expected 2 0 0 0 1 0",
               a_state, a_winner, a_ws, a_wd, a_xs, a_os); end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== model_snap(m)) begin errors++;
        $display("FAIL row_model dut%0d got %h expected %h", m, obs_of(m), model_snap(m)); end
    end
  endtask

  task automatic test_tie();
    int cells[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int d;
    press(B_NG);
    for (int i = 0; i < 9; i++) begin
      place(0, cells[i], d);
      checks++;
      if (d != 36) begin errors++;
        $display("FAIL tie_check_cycles move%0d got %0d expected 36", i, d); end
    end
    checks++;
    if (a_state !== 2'd3 || a_xs !== 2'd1 || a_os !== 2'd0 || a_mc !== 5'd9) begin errors++;
      $display("FAIL tie_state state %0d x %0d o %0d moves %0d expected 3 1 0 9", a_state, a_xs, a_os, a_mc); end
    press(B_SEL);
    checks++;
    if (a_state !== 2'd0 || a_used !== 9'd0 || a_mc !== 5'd0) begin errors++;
      $display("FAIL tie_restart state %0d used %h moves %0d expected 0 0 0", a_state, a_used, a_mc); end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== model_snap(m)) begin errors++;
        $display("FAIL tie_model dut%0d got %h expected %h", m, obs_of(m), model_snap(m)); end
    end
  endtask

  task automatic test_diag();
    int cells[5] = '{3, 0, 6, 12, 9};
    int durs[5]  = '{64, 64, 64, 64, 16};
    int d;
    press(B_NG);
    if (mturn[1] != 0) press(B_NG);
    for (int i = 0; i < 5; i++) begin
      place(1, cells[i], d);
      checks++;
      if (d != durs[i]) begin errors++;
        $display("FAIL diag_check_cycles move%0d got %0d expected %0d", i, d, durs[i]); end
    end
    checks++;
    if (b_state !== 2'd2 || b_winner !== 1'b0 || b_ws !== 4'd3 || b_wd !== 2'd3) begin errors++;
      $display("FAIL diag_win state %0d winner %0d start %0d dir %0d expected 2 0 3 3",
               b_state, b_winner, b_ws, b_wd); end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== model_snap(m)) begin errors++;
        $display("FAIL diag_model dut%0d got %h expected %h", m, obs_of(m), model_snap(m)); end
    end
  endtask

  task automatic test_saturation();
    int cells[5] = '{0, 3, 1, 4, 2};
    int expx[4]  = '{1, 2, 3, 3};
    int d;
    press(B_NG | B_CS);
    checks++;
    if (a_xs !== 2'd0 || a_os !== 2'd0 || b_xs !== 4'd0 || b_os !== 4'd0 ||
        a_used !== 9'd0 || b_used !== 16'd0) begin errors++;
      $display("FAIL clear_with_new scores %0d %0d %0d %0d used %h %h expected all 0",
               a_xs, a_os, b_xs, b_os, a_used, b_used); end
    for (int g = 0; g < 4; g++) begin
      press(B_NG);
      for (int i = 0; i < 5; i++) place(0, cells[i], d);
      checks++;
      if (a_xs !== 2'(expx[g])) begin errors++;
        $display("FAIL saturate game%0d got %0d expected %0d", g, a_xs, expx[g]); end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== model_snap(m)) begin errors++;
        $display("FAIL saturate_model dut%0d got %h expected %h", m, obs_of(m), model_snap(m)); end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    press(B_NG);
    press(B_SEL | B_RT);
    checks++;
    if (a_cursor !== 4'd4 || a_used[4] !== 1'b1 || a_state !== 2'd1) begin errors++;
      $display("FAIL sel_over_right cursor %0d used4 %0d state %0d expected 4 1 1", a_cursor, a_used[4], a_state); end
    run_check(0, d);
    press(B_UP | B_LF);
    checks++;
    if (a_cursor !== 4'd1) begin errors++;
      $display("FAIL up_over_left got %0d expected 1", a_cursor); end
    press(B_CS | B_RT);
    checks++;
    if (a_cursor !== 4'd1) begin errors++;
      $display("FAIL clear_over_right got %0d expected 1", a_cursor); end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== model_snap(m)) begin errors++;
        $display("FAIL priority_model dut%0d got %h expected %h", m, obs_of(m), model_snap(m)); end
    end
  endtask

  task automatic test_async_reset();
    press(B_NG);
    press(B_SEL);
    repeat (5) tick();
    checks++;
    if (a_busy !== 1'b1) begin errors++;
      $display("FAIL pre_reset_busy got %0d expected 1", a_busy); end
    #3 reset_n = 1'b0;
    mreset(0); mreset(1);
    #1;
    checks++;
    if (a_state !== 2'd0 || a_busy !== 1'b0 || a_cursor !== 4'd4 || a_used !== 9'd0 || a_mc !== 5'd0) begin errors++;
      $display("FAIL async_reset state %0d busy %0d cursor %0d used %h moves %0d expected 0 0 4 0 0",
               a_state, a_busy, a_cursor, a_used, a_mc); end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== model_snap(m)) begin errors++;
        $display("FAIL async_model dut%0d got %h expected %h", m, obs_of(m), model_snap(m)); end
    end
    #2 reset_n = 1'b1;
    press(B_SEL);
    checks++;
    if (a_used !== 9'h010 || a_sign[4] !== 1'b0 || a_state !== 2'd1) begin errors++;
      $display("FAIL first_sel used %h sign4 %0d state %0d expected 010 0 1", a_used, a_sign[4], a_state); end
  endtask

  task automatic test_alt_start();
    logic expt[3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      press(B_NG);
      checks++;
      if (b_turn !== expt[i] || a_turn !== 1'b0) begin errors++;
        $display("FAIL alt_start game%0d got %0d/%0d expected %0d/0", i, b_turn, a_turn, expt[i]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 2500; t++) begin
      new_game     = ($urandom_range(0, 79) == 0);
      clear_scores = ($urandom_range(0, 149) == 0);
      btn_sel      = ($urandom_range(0, 2) == 0);
      btn_up       = ($urandom_range(0, 3) == 0);
      btn_down     = ($urandom_range(0, 3) == 0);
      btn_left     = ($urandom_range(0, 3) == 0);
      btn_right    = ($urandom_range(0, 3) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_of(m) !== model_snap(m)) begin errors++;
          $display("FAIL random cycle%0d dut%0d got %h expected %h", t, m, obs_of(m), model_snap(m)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_win_row();
    test_tie();
    test_diag();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    test_alt_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
